// File: rtl/cdb_arbiter_if.sv
// Bundle between the FU completion ports / writeback stage and the CDB arbiter.
// The master side drives completions and cdb_ready; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int N_FU   = 4,
  parameter int DATA_W = 32
);
  localparam int SRC_W = $clog2(N_FU);

  logic                     flush;
  logic [N_FU-1:0]          req_valid;
  logic [N_FU*DATA_W-1:0]   req_data;
  logic [N_FU-1:0]          fu_hold;
  logic                     cdb_valid;
  logic [DATA_W-1:0]        cdb_data;
  logic [SRC_W-1:0]         cdb_src;
  logic                     cdb_ready;
  logic                     overflow_err;

  modport master (
    output flush, req_valid, req_data, cdb_ready,
    input  fu_hold, cdb_valid, cdb_data, cdb_src, overflow_err
  );

  modport slave (
    input  flush, req_valid, req_data, cdb_ready,
    output fu_hold, cdb_valid, cdb_data, cdb_src, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Buffers one-cycle FU completions in per-port FIFOs and grants the single CDB
// round-robin, one entry per cycle, with per-port issue hold and sticky overflow flag.
module cdb_arbiter #(
  parameter int N_FU   = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  cdb_arbiter_if.slave  bus
);
  localparam int SRC_W  = $clog2(N_FU);
  localparam int SCAN_W = SRC_W + 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [SCAN_W-1:0] N_FU_S  = SCAN_W'(N_FU);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  HOLD_C  = CNT_W'(DEPTH - 1);

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              overflow_q, overflow_d;
  logic [N_FU-1:0]   not_empty;
  logic [N_FU-1:0]   pop_vec;
  logic [N_FU-1:0]   drop_vec;
  logic [N_FU-1:0]   hold_vec;
  logic [DATA_W-1:0] head [N_FU];
  logic              grant_valid;
  logic [SRC_W-1:0]  grant_idx;
  logic [SCAN_W-1:0] scan_idx;
  logic              pop;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = N_FU - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + SCAN_W'(k);
      if (scan_idx >= N_FU_S) begin
        scan_idx = scan_idx - N_FU_S;
      end
      if (not_empty[scan_idx[SRC_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[SRC_W-1:0];
      end
    end
  end

  assign pop           = grant_valid && bus.cdb_ready;
  assign bus.cdb_valid = grant_valid;
  assign bus.cdb_src   = grant_idx;
  assign bus.cdb_data  = grant_valid ? head[grant_idx] : '0;
  assign bus.fu_hold   = hold_vec;
  assign bus.overflow_err = overflow_q;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    overflow_d = overflow_q | (|drop_vec);
    if (pop && !bus.flush) begin
      rr_ptr_d = (grant_idx == SRC_W'(N_FU - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar gi = 0; gi < N_FU; gi++) begin : g_port
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;

    assign pop_vec[gi]  = pop && (grant_idx == SRC_W'(gi));
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign push_ok      = bus.req_valid[gi] && !bus.flush && ((count_q != DEPTH_C) || pop_vec[gi]);
    assign drop_vec[gi] = bus.req_valid[gi] && !bus.flush && (count_q == DEPTH_C) && !pop_vec[gi];
    assign count_d      = count_q + CNT_W'(push_ok) - CNT_W'(pop_vec[gi]);

    always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop_vec[gi]) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        count_q <= count_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst_n && push_ok) begin
        mem_q[wr_ptr_q] <= bus.req_data[gi*DATA_W +: DATA_W];
      end
    end

    assign not_empty[gi] = (count_q != '0);
    assign head[gi]      = mem_q[rd_ptr_q];
    // Reserve the last slot: an FU issued this cycle may complete next cycle.
    assign hold_vec[gi]  = (count_q >= HOLD_C);
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_cdb_arbiter;
  localparam int N_FU   = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_FU(N_FU), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.N_FU(N_FU), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mq [N_FU][$];
  int rr;
  bit ovf;
  bit live = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_grant(output bit gv, output int w);
    gv = 1'b0;
    w  = 0;
    for (int k = 0; k < N_FU; k++) begin
      int p;
      p = (rr + k) % N_FU;
      if (!gv && mq[p].size() > 0) begin
        gv = 1'b1;
        w  = p;
      end
    end
  endtask

  task automatic model_step();
    bit gv;
    int w;
    logic [DATA_W-1:0] tmp;
    if (!rst_n) begin
      for (int i = 0; i < N_FU; i++) mq[i].delete();
      rr   = 0;
      ovf  = 1'b0;
      live = 1'b1;
    end else if (bus.flush) begin
      for (int i = 0; i < N_FU; i++) mq[i].delete();
    end else begin
      model_grant(gv, w);
      if (gv && bus.cdb_ready) begin
        tmp = mq[w].pop_front();
        rr  = (w + 1) % N_FU;
      end
      for (int i = 0; i < N_FU; i++) begin
        if (bus.req_valid[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(bus.req_data[i*DATA_W +: DATA_W]);
          else ovf = 1'b1;
        end
      end
    end
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin : compare_proc
    bit gv;
    int w;
    bit hold_pending;
    logic [DATA_W-1:0] prev_data;
    logic [N_FU-1:0] exp_hold;
    hold_pending = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (live) begin
        model_grant(gv, w);
        chk("cdb_valid", 32'(bus.cdb_valid), 32'(gv));
        chk("cdb_src", 32'(bus.cdb_src), gv ? w : 0);
        chk("cdb_data", bus.cdb_data, gv ? mq[w][0] : '0);
        for (int i = 0; i < N_FU; i++) exp_hold[i] = (mq[i].size() >= DEPTH - 1);
        chk("fu_hold", 32'(bus.fu_hold), 32'(exp_hold));
        chk("overflow_err", 32'(bus.overflow_err), 32'(ovf));
        if (hold_pending) chk("data_stable", bus.cdb_data, prev_data);
        hold_pending = bus.cdb_valid && !bus.cdb_ready && !bus.flush && rst_n && (bus.req_valid == '0);
        prev_data = bus.cdb_data;
        if (bus.cdb_valid && bus.cdb_ready && rst_n && !bus.flush)
          $display("cdb grant src=%0d data=%h", bus.cdb_src, bus.cdb_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic [31:0] d);
    bus.req_valid[p] = 1'b1;
    bus.req_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic clr();
    bus.req_valid = '0;
  endtask

  task automatic lit(input string name, input logic v, input int src, input logic [31:0] d);
    chk({name, "_valid"}, 32'(bus.cdb_valid), 32'(v));
    chk({name, "_src"}, 32'(bus.cdb_src), src);
    chk({name, "_data"}, bus.cdb_data, d);
  endtask

  initial begin : stim
    bus.flush     = 1'b0;
    bus.cdb_ready = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};

    // Reset with pushes asserted: all lost
    tick(); tick();
    rst_n = 1'b1;
    clr();
    lit("rst", 1'b0, 0, 32'h0);
    chk("rst_hold", 32'(bus.fu_hold), 32'h0);
    chk("rst_ovf", 32'(bus.overflow_err), 32'h0);
    tick();
    lit("rst_lost", 1'b0, 0, 32'h0);

    // Single port
    push(2, 32'hAAAA0001);
    tick(); clr();
    lit("single", 1'b1, 2, 32'hAAAA0001);
    tick();
    lit("single_idle", 1'b0, 0, 32'h0);

    // Bring rr_ptr to 0, then all four ports at once
    push(3, 32'h99);
    tick(); clr();
    tick();
    for (int p = 0; p < N_FU; p++) push(p, 32'h10 + p);
    tick(); clr();
    for (int k = 0; k < N_FU; k++) begin
      lit("rr0", 1'b1, k, 32'h10 + k);
      tick();
    end
    lit("rr0_end", 1'b0, 0, 32'h0);

    // Bring rr_ptr to 2, repeat
    push(1, 32'h98);
    tick(); clr();
    tick();
    for (int p = 0; p < N_FU; p++) push(p, 32'h10 + p);
    tick(); clr();
    for (int k = 0; k < N_FU; k++) begin
      lit("rr2", 1'b1, (2 + k) % N_FU, 32'h10 + ((2 + k) % N_FU));
      tick();
    end
    lit("rr2_end", 1'b0, 0, 32'h0);

    // Backpressure and overflow on port 1
    bus.cdb_ready = 1'b0;
    push(1, 32'h21);
    tick(); clr();
    lit("bp1", 1'b1, 1, 32'h21);
    chk("bp1_hold", 32'(bus.fu_hold), 32'h2);
    push(1, 32'h22);
    tick(); clr();
    lit("bp2", 1'b1, 1, 32'h21);
    chk("bp2_ovf", 32'(bus.overflow_err), 32'h0);
    push(1, 32'h23);
    tick(); clr();
    chk("bp3_ovf", 32'(bus.overflow_err), 32'h1);
    lit("bp3", 1'b1, 1, 32'h21);
    bus.cdb_ready = 1'b1;
    tick();
    lit("bp_drain", 1'b1, 1, 32'h22);
    tick();
    lit("bp_end", 1'b0, 0, 32'h0);

    // Reset clears the sticky flag
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_ovf", 32'(bus.overflow_err), 32'h0);

    // Push and pop together on a full port
    bus.cdb_ready = 1'b0;
    push(0, 32'h31);
    tick();
    push(0, 32'h32);
    tick(); clr();
    lit("full", 1'b1, 0, 32'h31);
    chk("full_hold", 32'(bus.fu_hold), 32'h1);
    bus.cdb_ready = 1'b1;
    push(0, 32'h33);
    tick(); clr();
    lit("pp1", 1'b1, 0, 32'h32);
    chk("pp_ovf", 32'(bus.overflow_err), 32'h0);
    chk("pp_hold", 32'(bus.fu_hold), 32'h1);
    tick();
    lit("pp2", 1'b1, 0, 32'h33);
    tick();
    lit("pp_end", 1'b0, 0, 32'h0);
    chk("pp_end_hold", 32'(bus.fu_hold), 32'h0);

    // Flush with overflow already set; rr_ptr is 1 here
    bus.cdb_ready = 1'b0;
    push(2, 32'h41);
    tick();
    push(2, 32'h42);
    tick();
    push(2, 32'h43);
    tick(); clr();
    chk("fl_ovf_pre", 32'(bus.overflow_err), 32'h1);
    push(0, 32'h44);
    tick(); clr();
    bus.flush = 1'b1;
    push(3, 32'h45);
    tick();
    bus.flush = 1'b0;
    clr();
    lit("flush", 1'b0, 0, 32'h0);
    chk("flush_hold", 32'(bus.fu_hold), 32'h0);
    chk("flush_ovf", 32'(bus.overflow_err), 32'h1);
    bus.cdb_ready = 1'b1;
    push(0, 32'h50);
    push(2, 32'h52);
    tick(); clr();
    lit("post_flush_rr", 1'b1, 2, 32'h52);
    tick();
    lit("post_flush_2", 1'b1, 0, 32'h50);
    tick();
    lit("post_flush_end", 1'b0, 0, 32'h0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) among N functional-unit completion ports (ALU instances and other FUs).
- Each FU drives a completion for one cycle only, with no backpressure, so every port gets a small FIFO.
- Ports are granted the CDB round-robin, one completion per cycle, to the scoreboard writeback stage.
- Per-port hold outputs tell the scoreboard issue logic to stop issuing to an FU whose buffer could overflow.

Parameters:
- N_FU, 4, number of FU completion ports (2..8).
- DATA_W, 32, width of one flattened completion record (cdb payload).
- DEPTH, 2, entries per port FIFO (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  discard all buffered completions.
- req_valid  in  N_FU  per-FU complete_valid, one-cycle pulse per result.
- req_data  in  N_FU*DATA_W  per-FU completion payload; port i occupies bits [i*DATA_W +: DATA_W].
- fu_hold  out  N_FU  1 = scoreboard must not issue to FU i this cycle.
- cdb_valid  out  1  a completion is presented on the CDB.
- cdb_data  out  DATA_W  payload of the granted entry.
- cdb_src  out  $clog2(N_FU)  index of the granted port.
- cdb_ready  in  1  writeback accepts the CDB entry this cycle.
- overflow_err  out  1  sticky error: a push arrived at a full FIFO.

Behaviour:
- Reset and clocking:
  - Reset is sampled on the clk rising edge when rst_n=0.
  - On reset: all FIFOs empty (count=0, rd/wr pointers 0), rr_ptr=0, overflow_err=0.
  - Resulting outputs: cdb_valid=0, cdb_data=0, cdb_src=0, fu_hold=0.
  - Reset has priority over flush and over all pushes/pops in the same cycle.
- Push:
  - req_valid[i]=1 at edge t writes req_data slice i into FIFO i; count[i]++.
  - No ready handshake toward FUs; a push is never refused.
- Overflow:
  - Push when count[i]==DEPTH and port i is not popped in the same cycle: data dropped, FIFO unchanged, overflow_err <= 1.
  - overflow_err stays high until reset; flush does not clear it.
- Grant (combinational, from registered state):
  - Scan ports rr_ptr, rr_ptr+1, … (mod N_FU); the first non-empty FIFO wins.
  - cdb_valid=1, cdb_src=winner, cdb_data=head of FIFO[winner].
  - All FIFOs empty: cdb_valid=0, cdb_data=0, cdb_src=0.
- Pop:
  - Occurs only when cdb_valid && cdb_ready.
  - FIFO[winner] pops at the edge; rr_ptr <= (winner+1) mod N_FU.
  - If no pop, rr_ptr holds and the same entry stays presented (stable while !cdb_ready).
- Latency: push at edge t → earliest cdb_valid in the cycle after edge t. No same-cycle bypass from req_valid to cdb.
- Simultaneous push and pop on the same port: both take effect, count unchanged; legal even when full (no overflow).
- Flush:
  - All FIFOs emptied, so cdb_valid=0 the next cycle.
  - rr_ptr unchanged.
  - req_valid in the flush cycle is discarded.
- Throughput: at most one CDB entry per cycle. Order within a port is FIFO; order across ports is round-robin.
- fu_hold[i] = (count[i] ≥ DEPTH−1), combinational from registered count.
  - Rationale: an issue at edge t completes at t+1, so the last free slot is reserved.
  - Multi-cycle FUs use the same rule.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Assertions (bench-side): count[i] ≤ DEPTH; cdb_data stable while cdb_valid && !cdb_ready.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles while req_valid=4'b1111 → after release cdb_valid=0, fu_hold=0, overflow_err=0; the pushes during reset are lost.
2. Single port, cdb_ready=1: push 0xAAAA0001 on port 2 at edge t → cycle t+1 shows cdb_valid=1, cdb_src=2, cdb_data=0xAAAA0001; idle thereafter.
3. Round-robin, cdb_ready=1: push ports 0–3 simultaneously with payloads 0x10, 0x11, 0x12, 0x13, rr_ptr=0 → the next 4 cycles grant src 0,1,2,3 in order, then cdb_valid=0. Repeat with rr_ptr=2 → order 2,3,0,1.
4. Backpressure: cdb_ready=0, push port 1 twice (0x21, 0x22) → fu_hold[1]=1 after the first push; cdb_data stays 0x21. A third push → overflow_err=1 and 0x22 is retained. Then cdb_ready=1 → 0x21 then 0x22 are output.
5. Push+pop at full: port 0 full (0x31, 0x32), cdb_ready=1, push 0x33 in the same cycle → no overflow, count stays 2, outputs in order 0x31, 0x32, 0x33.
6. Flush: 3 entries buffered across ports, with flush=1 and req_valid[3]=1 in the same cycle → next cycle cdb_valid=0, fu_hold=0, overflow_err unchanged, rr_ptr unchanged.
